// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file: geometry, counter width
// and the indices of the memory-mapped GPIO/UART registers.
package regfile_pkg;

    localparam int DEF_XLEN         = 32;
    localparam int DEF_NREG         = 32;
    localparam int DEF_NRP          = 2;
    localparam int DEF_CNT_W        = 2;
    localparam int DEF_GPIO_W       = 8;
    localparam int DEF_GPIO_OUT_REG = 10;
    localparam int DEF_GPIO_IN_REG  = 11;
    localparam int DEF_UART_REG     = 12;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters plus the issue-ready and per-port busy
// logic derived from them. x0 never holds a count.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int NRP   = DEF_NRP,
    parameter int CNT_W = DEF_CNT_W,
    parameter int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRP*AW-1:0] rp_addr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    output logic [NRP-1:0]    rp_busy,
    output logic              iss_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NREG];
    logic             wb_live;
    logic             same_rd;
    logic             iss_fire;

    assign wb_live   = wb_valid && (wb_rd != '0);
    assign same_rd   = wb_live && (wb_rd == iss_rd);
    // A saturated register can still take an issue when a writeback to it
    // lands in the same cycle, because the net count does not move.
    assign iss_ready = (iss_rd == '0) || (cnt[iss_rd] != CNT_MAX) || same_rd;
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (iss_fire && (iss_rd == AW'(i))) begin
                    if (!(wb_live && (wb_rd == AW'(i)))) cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (wb_live && (wb_rd == AW'(i)) && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_busy
        logic [AW-1:0] a;
        assign a          = rp_addr[p*AW +: AW];
        assign rp_busy[p] = (cnt[a] != '0) &&
                            !(wb_live && (wb_rd == a) && (cnt[a] == CNT_W'(1)) &&
                              !(iss_fire && (iss_rd == a)));
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write bypass, pending-write scoreboard, a synchronised
// GPIO input register, a GPIO output register and a UART holding register.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN         = DEF_XLEN,
    parameter int NREG         = DEF_NREG,
    parameter int NRP          = DEF_NRP,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int GPIO_W       = DEF_GPIO_W,
    parameter int GPIO_OUT_REG = DEF_GPIO_OUT_REG,
    parameter int GPIO_IN_REG  = DEF_GPIO_IN_REG,
    parameter int UART_REG     = DEF_UART_REG
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRP*$clog2(NREG)-1:0] rp_addr,
    output logic [NRP*XLEN-1:0]        rp_data,
    output logic [NRP-1:0]             rp_busy,
    input  logic                       iss_valid,
    input  logic [$clog2(NREG)-1:0]    iss_rd,
    output logic                       iss_ready,
    input  logic                       wb_valid,
    input  logic [$clog2(NREG)-1:0]    wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic [GPIO_W-1:0]          gpio_in,
    output logic [GPIO_W-1:0]          gpio_out,
    output logic [7:0]                 uart_data,
    output logic                       uart_valid,
    input  logic                       uart_ready,
    output logic                       uart_ovf
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]   regs [NREG];
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;
    logic [XLEN-1:0]   gpio_rd;
    logic              wr_en;
    logic              uart_wr;

    // The GPIO input register is a read-only view of the pins, so it is
    // excluded from both the array write and the read bypass.
    assign wr_en   = wb_valid && (wb_rd != '0) && (wb_rd != AW'(GPIO_IN_REG));
    assign uart_wr = wb_valid && (wb_rd == AW'(UART_REG));
    assign gpio_rd = {{(XLEN-GPIO_W){1'b0}}, gpio_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
        end
    end

    assign gpio_out = regs[GPIO_OUT_REG][GPIO_W-1:0];

    for (genvar p = 0; p < NRP; p++) begin : g_read
        logic [AW-1:0] a;
        assign a = rp_addr[p*AW +: AW];
        assign rp_data[p*XLEN +: XLEN] =
            (a == '0)                 ? '0      :
            (a == AW'(GPIO_IN_REG))   ? gpio_rd :
            (wb_valid && wb_rd == a)  ? wb_data :
                                        regs[a];
    end

    // uart_valid/uart_ready: a byte moves on any edge where both are high;
    // valid then drops unless a new UART_REG write reloads it that cycle.
    // Writing while valid && !ready overwrites the byte and flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_data  <= '0;
            uart_valid <= 1'b0;
            uart_ovf   <= 1'b0;
        end else if (uart_wr) begin
            uart_data  <= wb_data[7:0];
            uart_valid <= 1'b1;
            if (uart_valid && !uart_ready) uart_ovf <= 1'b1;
        end else if (uart_valid && uart_ready) begin
            uart_valid <= 1'b0;
        end
    end

    rf_scoreboard #(
        .NREG  (NREG),
        .NRP   (NRP),
        .CNT_W (CNT_W),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rp_addr   (rp_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .rp_busy   (rp_busy),
        .iss_ready (iss_ready)
    );

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL take parameters: XLEN 32, register width; NREG 32, register count (power of 2); NRP 2, read-port count; CNT_W 2, pending-counter width; GPIO_W 8, GPIO width; GPIO_OUT_REG 10, GPIO output register; GPIO_IN_REG 11, GPIO input register; UART_REG 12, UART data register.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 rp_addr  in  NRP*log2(NREG)  packed read addresses.
REQ-006 rp_data  out  NRP*XLEN  packed read data, combinational.
REQ-007 rp_busy  out  NRP  per-port pending-write flag, combinational.
REQ-008 iss_valid  in  1  issue marks iss_rd pending.
REQ-009 iss_rd  in  log2(NREG)  issue destination.
REQ-010 iss_ready  out  1  issue accepted this cycle.
REQ-011 wb_valid  in  1  writeback strobe.
REQ-012 wb_rd  in  log2(NREG)  writeback destination.
REQ-013 wb_data  in  XLEN  writeback data.
REQ-014 gpio_in  in  GPIO_W  asynchronous pins.
REQ-015 gpio_out  out  GPIO_W  = GPIO_OUT_REG[GPIO_W-1:0].
REQ-016 uart_data  out  8  UART holding byte.
REQ-017 uart_valid  out  1  holding byte pending.
REQ-018 uart_ready  in  1  consumer accepts byte.
REQ-019 uart_ovf  out  1  sticky overrun flag.

Function
REQ-020 x0 SHALL read 0, never go busy, and ignore issue and writeback; issue to x0 SHALL have iss_ready=1.
REQ-021 A writeback with wb_valid=1 and wb_rd!=0 SHALL update regs[wb_rd] on the next edge.
REQ-022 Write bypass: a read port SHALL return wb_data when wb_valid=1, wb_rd=addr and addr!=0.
REQ-023 Each register SHALL keep a CNT_W-bit pending counter.
REQ-024 Issue SHALL increment the counter and matching writeback SHALL decrement it.
REQ-025 Issue and writeback to the same register in one cycle SHALL leave its counter unchanged.
REQ-026 iss_ready SHALL be 0 when count[iss_rd] is at its maximum value and that cycle has no same-register writeback; a rejected issue SHALL change nothing.
REQ-027 A writeback to a register whose count is 0 SHALL write data but leave the count at 0, with no underflow.
REQ-028 rp_busy SHALL be count[addr]!=0, except 0 when a same-cycle writeback to addr reduces the count to 0.
REQ-029 gpio_in SHALL pass a 2-flop synchroniser; GPIO_IN_REG SHALL read the zero-extended synchronised value; writes to it SHALL be discarded.
REQ-030 A writeback to UART_REG SHALL store the register, load uart_data=wb_data[7:0] and set uart_valid next cycle.
REQ-031 A byte SHALL transfer when uart_valid and uart_ready are both 1; uart_valid SHALL then clear unless a same-cycle UART_REG write reloads it.
REQ-032 A UART_REG write while uart_valid=1 and uart_ready=0 SHALL overwrite uart_data and set uart_ovf until reset.

Reset
REQ-033 rst_n low SHALL clear, asynchronously: all registers, all counters, synchroniser flops, uart_data, uart_valid, uart_ovf; outputs 0 and iss_ready=1.
REQ-034 Reset during pending issues SHALL drop all pending state, with no completion implied.

Structure
REQ-035 regfile_pkg SHALL hold the default XLEN, NREG, CNT_W and the special register indices.
REQ-036 Counters and the busy/ready logic SHALL live in sub-module rf_scoreboard.

Verification
REQ-037 wb x5=0x1234 while port0 reads x5 -> rp_data0=0x1234 same cycle; next cycle from array.
REQ-038 issue x7 three times, then a fourth -> iss_ready=0, count stays 3; three writebacks -> rp_busy=0.
REQ-039 count x3=1, issue+wb x3 same cycle -> count stays 1, busy=1; wb x3 alone -> busy 0 that cycle.
REQ-040 gpio_in=0xA5 -> GPIO_IN_REG reads 0xA5 after two edges; wb x11=0xFF -> still 0xA5.
REQ-041 wb x12=0x41, uart_ready=0; wb x12=0x42 -> uart_data=0x42, uart_ovf=1; uart_ready=1 -> uart_valid falls.
REQ-042 assert rst_n mid-activity between edges -> all outputs 0, iss_ready=1 immediately.
